// File: rtl/alignment_collector_pkg.sv
// -----------------------------------------------------------------------------
// alignment_collector_pkg
// Shared definitions for the alignment collector slice:
//   - base encodings used on the traceback pair stream (gap, none)
//   - collector FSM state encoding
//   - pair classification (match / mismatch / gap)
//   - saturating clamp for the signed alignment score
// -----------------------------------------------------------------------------
package alignment_collector_pkg;

    // Base encodings on the (r, q) pair stream.
    localparam logic [2:0] BASE_GAP  = 3'b100;
    localparam logic [2:0] BASE_NONE = 3'b111;

    // Collector FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Category of one alignment column.
    typedef enum logic [1:0] {
        CLS_MATCH    = 2'd0,
        CLS_MISMATCH = 2'd1,
        CLS_GAP      = 2'd2
    } pair_class_e;

    // A gap on either side wins over the base comparison.
    function automatic pair_class_e classify_pair(input logic [2:0] r, input logic [2:0] q);
        pair_class_e cls;
        if ((r == BASE_GAP) || (q == BASE_GAP)) begin
            cls = CLS_GAP;
        end else if (r == q) begin
            cls = CLS_MATCH;
        end else begin
            cls = CLS_MISMATCH;
        end
        return cls;
    endfunction

    // Clamp a wide intermediate score into the signed range of an sw-bit
    // two's-complement value, so the running score never wraps.
    function automatic int sat_score(input int value, input int sw);
        int max_v;
        int min_v;
        int res;
        max_v = (32'sd1 <<< (sw - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (sw - 1));
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/alignment_collector_if.sv
// -----------------------------------------------------------------------------
// alignment_collector_if
// Forward-order pair stream leaving the collector (valid/ready handshake).
//   out_valid : pair available (driven by master)
//   out_ready : consumer accepts the pair (driven by slave)
//   out_r     : reference base or gap
//   out_q     : query base or gap
//   out_last  : current pair is the final alignment column
// -----------------------------------------------------------------------------
interface alignment_collector_if;

    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_r;
    logic [2:0] out_q;
    logic       out_last;

    modport master (
        output out_valid,
        output out_r,
        output out_q,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_r,
        input  out_q,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/alignment_lifo.sv
// -----------------------------------------------------------------------------
// alignment_lifo
// Register-array stack holding captured (r, q) pairs as 6-bit words {r, q}.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   clear      : synchronous pointer clear
//   push       : write push_data at ptr and increment (ignored when full)
//   pop        : decrement ptr (ignored when empty)
//   ptr        : number of stored entries
//   full/empty : stack status
//   rd_top     : mem[ptr-1], the entry a pop would remove
//   rd_next    : mem[ptr-2], the entry that becomes top after one pop
// push and pop are never requested in the same cycle by the owner.
// -----------------------------------------------------------------------------
module alignment_lifo #(
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [5:0]    push_data,
    input  logic          pop,
    output logic [PW-1:0] ptr,
    output logic          full,
    output logic          empty,
    output logic [5:0]    rd_top,
    output logic [5:0]    rd_next
);

    logic [5:0]    mem_r [DEPTH];
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] top_idx_s;
    logic [PW-1:0] next_idx_s;
    logic          full_s;
    logic          empty_s;

    // Status flags and the two read taps used for zero-bubble draining.
    always_comb begin
        full_s     = (ptr_r == PW'(DEPTH));
        empty_s    = (ptr_r == {PW{1'b0}});
        top_idx_s  = ptr_r - PW'(1);
        next_idx_s = ptr_r - PW'(2);
        rd_top     = mem_r[top_idx_s[IW-1:0]];
        rd_next    = mem_r[next_idx_s[IW-1:0]];
    end

    // Stack pointer: clear has priority, then push, then pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PW{1'b0}};
        end else if (clear) begin
            ptr_r <= {PW{1'b0}};
        end else if (push && !full_s) begin
            ptr_r <= ptr_r + PW'(1);
        end else if (pop && !empty_s) begin
            ptr_r <= ptr_r - PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Storage array; contents are meaningless below ptr after reset, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full_s) begin
            mem_r[ptr_r[IW-1:0]] <= push_data;
        end
    end

    assign ptr   = ptr_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/alignment_collector.sv
// -----------------------------------------------------------------------------
// alignment_collector
// Captures the reverse-order (r, q) pair stream produced by traceback, keeps
// running alignment statistics, then replays the pairs in forward order over a
// valid/ready interface.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start_traceback    : level; its rising edge in IDLE starts a capture,
//                        its fall during capture aborts
//   tb_out_r/tb_out_q  : traceback pair (4 = gap, 7 = none)
//   tb_finish          : traceback finished; this cycle's pair is the last one
//   out_if (master)    : forward-order stream out_valid/out_ready/out_r/out_q/out_last
//   n_match/n_mismatch/n_gap : column counts of the captured alignment
//   score              : saturating signed score
//   busy               : capture or drain in progress
//   done               : one-cycle pulse when the alignment has been delivered
//   overflow           : sticky, more pairs offered than the buffer holds
// -----------------------------------------------------------------------------
module alignment_collector
    import alignment_collector_pkg::*;
#(
    parameter  int L        = 8,
    parameter  int MATCH    = 2,
    parameter  int MISMATCH = 1,
    parameter  int GAP      = 2,
    parameter  int SW       = 8,
    localparam int DEPTH    = 2 * L,
    localparam int CW       = $clog2(2 * L + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_traceback,
    input  logic [2:0]           tb_out_r,
    input  logic [2:0]           tb_out_q,
    input  logic                 tb_finish,
    alignment_collector_if.master out_if,
    output logic [CW-1:0]        n_match,
    output logic [CW-1:0]        n_mismatch,
    output logic [CW-1:0]        n_gap,
    output logic signed [SW-1:0] score,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    state_e               state_r;
    state_e               state_next_s;
    logic                 start_d_r;

    logic [CW-1:0]        n_match_r;
    logic [CW-1:0]        n_mismatch_r;
    logic [CW-1:0]        n_gap_r;
    logic signed [SW-1:0] score_r;
    logic                 overflow_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 out_valid_r;
    logic [2:0]           out_r_r;
    logic [2:0]           out_q_r;
    logic                 out_last_r;

    logic                 start_rise_s;
    logic                 pair_valid_s;
    logic                 handshake_s;
    pair_class_e          cls_s;
    int                   delta_s;
    int                   score_sum_s;
    int                   score_sat_s;

    logic                 clear_s;
    logic                 abort_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 load_first_s;
    logic                 load_next_s;
    logic                 finish_done_s;
    logic                 drain_done_s;

    logic [CW-1:0]        lifo_ptr_s;
    logic                 lifo_full_s;
    logic                 lifo_empty_s;
    logic [5:0]           lifo_top_s;
    logic [5:0]           lifo_next_s;

    alignment_lifo #(
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s | abort_s),
        .push      (push_s),
        .push_data ({tb_out_r, tb_out_q}),
        .pop       (pop_s),
        .ptr       (lifo_ptr_s),
        .full      (lifo_full_s),
        .empty     (lifo_empty_s),
        .rd_top    (lifo_top_s),
        .rd_next   (lifo_next_s)
    );

    // Pair qualification, classification and the saturated score update.
    always_comb begin
        start_rise_s = start_traceback & ~start_d_r;
        pair_valid_s = !((tb_out_r == BASE_NONE) && (tb_out_q == BASE_NONE));
        handshake_s  = out_valid_r & out_if.out_ready;
        cls_s        = classify_pair(tb_out_r, tb_out_q);
        case (cls_s)
            CLS_MATCH:    delta_s = MATCH;
            CLS_MISMATCH: delta_s = -MISMATCH;
            CLS_GAP:      delta_s = -GAP;
            default:      delta_s = 0;
        endcase
        score_sum_s = int'(score_r) + delta_s;
        score_sat_s = sat_score(score_sum_s, SW);
    end

    // FSM next state and the per-cycle control strobes.
    // The finish-cycle pair is stored like any other valid pair; a finish
    // presented with the (none, none) pair and nothing stored yet is an
    // empty capture and completes straight away.
    always_comb begin
        state_next_s  = state_r;
        clear_s       = 1'b0;
        abort_s       = 1'b0;
        push_s        = 1'b0;
        drop_s        = 1'b0;
        pop_s         = 1'b0;
        load_first_s  = 1'b0;
        load_next_s   = 1'b0;
        finish_done_s = 1'b0;
        drain_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_next_s = CAPTURE;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPTURE: begin
                if (!start_traceback) begin
                    state_next_s = IDLE;
                    abort_s      = 1'b1;
                end else begin
                    if (pair_valid_s) begin
                        if (lifo_full_s) begin
                            drop_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                    if (tb_finish) begin
                        if (push_s || !lifo_empty_s) begin
                            state_next_s = DRAIN;
                            load_first_s = 1'b1;
                        end else begin
                            state_next_s  = IDLE;
                            finish_done_s = 1'b1;
                        end
                    end else begin
                        state_next_s = CAPTURE;
                    end
                end
            end
            DRAIN: begin
                if (handshake_s) begin
                    pop_s = 1'b1;
                    if (out_last_r) begin
                        state_next_s = IDLE;
                        drain_done_s = 1'b1;
                    end else begin
                        load_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, start-edge history, busy and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            start_d_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            start_d_r <= start_traceback;
            busy_r    <= (state_next_s != IDLE);
            done_r    <= finish_done_s | drain_done_s;
        end
    end

    // Alignment statistics; cleared on a start edge, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_match_r    <= {CW{1'b0}};
            n_mismatch_r <= {CW{1'b0}};
            n_gap_r      <= {CW{1'b0}};
            score_r      <= {SW{1'b0}};
            overflow_r   <= 1'b0;
        end else if (clear_s) begin
            n_match_r    <= {CW{1'b0}};
            n_mismatch_r <= {CW{1'b0}};
            n_gap_r      <= {CW{1'b0}};
            score_r      <= {SW{1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            if (push_s) begin
                case (cls_s)
                    CLS_MATCH:    n_match_r    <= n_match_r + CW'(1);
                    CLS_MISMATCH: n_mismatch_r <= n_mismatch_r + CW'(1);
                    CLS_GAP:      n_gap_r      <= n_gap_r + CW'(1);
                    default:      n_gap_r      <= n_gap_r;
                endcase
                score_r <= score_sat_s[SW-1:0];
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output stage. On drain entry the newest pair is presented: the one
    // pushed this very edge, or the stack top when this edge pushed nothing.
    // On each handshake the entry below the top is preloaded so transfers
    // can run back to back. The data fields hold whenever valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r_r     <= BASE_NONE;
            out_q_r     <= BASE_NONE;
            out_last_r  <= 1'b0;
        end else if (load_first_s) begin
            out_valid_r <= 1'b1;
            if (push_s) begin
                out_r_r    <= tb_out_r;
                out_q_r    <= tb_out_q;
                out_last_r <= lifo_empty_s;
            end else begin
                out_r_r    <= lifo_top_s[5:3];
                out_q_r    <= lifo_top_s[2:0];
                out_last_r <= (lifo_ptr_s == CW'(1));
            end
        end else if (load_next_s) begin
            out_valid_r <= 1'b1;
            out_r_r     <= lifo_next_s[5:3];
            out_q_r     <= lifo_next_s[2:0];
            out_last_r  <= (lifo_ptr_s == CW'(2));
        end else if (drain_done_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_r     = out_r_r;
    assign out_if.out_q     = out_q_r;
    assign out_if.out_last  = out_last_r;
    assign n_match          = n_match_r;
    assign n_mismatch       = n_mismatch_r;
    assign n_gap            = n_gap_r;
    assign score            = score_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign overflow         = overflow_r;

endmodule
